// File: rtl/uart_rx_fifo.sv
// Receive buffer behind the UART receiver: first-word-fall-through byte FIFO.
// It also keeps sticky overrun and framing-error flags and drives a level-based irq.
module uart_rx_fifo #(
   parameter int DEPTH     = 8,
   parameter int IRQ_LEVEL = 1
) (
   input  logic                         clk,
   input  logic                         rst_n,
   input  logic                         i_rx_data_valid,
   input  logic [7:0]                   i_rx_data,
   input  logic                         i_rx_error,
   input  logic                         i_rd_en,
   input  logic                         i_flush,
   output logic [7:0]                   o_rdata,
   output logic                         o_rdata_err,
   output logic                         o_empty,
   output logic                         o_full,
   output logic [$clog2(DEPTH+1)-1:0]   o_level,
   output logic                         o_overrun,
   output logic                         o_frame_err,
   output logic                         o_irq
);

   localparam int AW = $clog2(DEPTH);
   localparam int LW = $clog2(DEPTH+1);
   localparam logic [LW-1:0] FULL_LVL = LW'(DEPTH);
   localparam logic [LW-1:0] IRQ_LVL  = LW'(IRQ_LEVEL);

   // Handshake: the receiver strobe has no back-pressure, so a byte that arrives
   // while full (with no pop in the same cycle) is dropped and flagged as overrun.
   // rd_en is a pop request that is honoured only when the FIFO is not empty.
   logic [8:0]    r_mem [DEPTH];
   logic [AW-1:0] r_wr_ptr;
   logic [AW-1:0] r_rd_ptr;
   logic [LW-1:0] r_level;
   logic          r_overrun;
   logic          r_frame_err;

   logic          w_empty;
   logic          w_full;
   logic          w_pop;
   logic          w_push;
   logic          w_drop;
   logic [8:0]    w_head;

   assign w_empty = (r_level == '0);
   assign w_full  = (r_level == FULL_LVL);
   assign w_pop   = i_rd_en & ~w_empty;
   assign w_push  = i_rx_data_valid & (~w_full | w_pop);
   assign w_drop  = i_rx_data_valid & w_full & ~w_pop;
   assign w_head  = r_mem[r_rd_ptr];

   // Storage is deliberately not reset; the empty mask hides stale entries.
   always_ff @(posedge clk) begin
      if (w_push && !i_flush) begin
         r_mem[r_wr_ptr] <= {i_rx_error, i_rx_data};
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_wr_ptr    <= '0;
         r_rd_ptr    <= '0;
         r_level     <= '0;
         r_overrun   <= 1'b0;
         r_frame_err <= 1'b0;
      end else if (i_flush) begin
         r_wr_ptr    <= '0;
         r_rd_ptr    <= '0;
         r_level     <= '0;
         r_overrun   <= 1'b0;
         r_frame_err <= 1'b0;
      end else begin
         if (w_push) begin
            r_wr_ptr <= r_wr_ptr + AW'(1);
         end
         if (w_pop) begin
            r_rd_ptr <= r_rd_ptr + AW'(1);
         end
         if (w_push && !w_pop) begin
            r_level <= r_level + LW'(1);
         end else if (w_pop && !w_push) begin
            r_level <= r_level - LW'(1);
         end
         if (w_drop) begin
            r_overrun <= 1'b1;
         end
         if (w_push && i_rx_error) begin
            r_frame_err <= 1'b1;
         end
      end
   end

   assign o_rdata     = w_empty ? 8'h00 : w_head[7:0];
   assign o_rdata_err = w_empty ? 1'b0  : w_head[8];
   assign o_empty     = w_empty;
   assign o_full      = w_full;
   assign o_level     = r_level;
   assign o_overrun   = r_overrun;
   assign o_frame_err = r_frame_err;
   assign o_irq       = (r_level >= IRQ_LVL) | r_overrun | r_frame_err;

endmodule

// File: tb/tb_uart_rx_fifo.sv
// Self-checking bench for uart_rx_fifo: directed scenarios plus a randomized run
// against a queue-based reference model.
module tb_uart_rx_fifo;

   localparam int DEPTH     = 8;
   localparam int IRQ_LEVEL = 1;

   logic       clk;
   logic       rst_n;
   logic       i_rx_data_valid;
   logic [7:0] i_rx_data;
   logic       i_rx_error;
   logic       i_rd_en;
   logic       i_flush;
   logic [7:0] o_rdata;
   logic       o_rdata_err;
   logic       o_empty;
   logic       o_full;
   logic [3:0] o_level;
   logic       o_overrun;
   logic       o_frame_err;
   logic       o_irq;

   int errors = 0;
   int checks = 0;

   // Reference model: queue of {err, data} plus the two sticky flags.
   logic [8:0] exp_q[$];
   logic       m_ovr;
   logic       m_ferr;

   uart_rx_fifo #(.DEPTH(DEPTH), .IRQ_LEVEL(IRQ_LEVEL)) dut (
      .clk             (clk),
      .rst_n           (rst_n),
      .i_rx_data_valid (i_rx_data_valid),
      .i_rx_data       (i_rx_data),
      .i_rx_error      (i_rx_error),
      .i_rd_en         (i_rd_en),
      .i_flush         (i_flush),
      .o_rdata         (o_rdata),
      .o_rdata_err     (o_rdata_err),
      .o_empty         (o_empty),
      .o_full          (o_full),
      .o_level         (o_level),
      .o_overrun       (o_overrun),
      .o_frame_err     (o_frame_err),
      .o_irq           (o_irq)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // One clock of stimulus; returns #1 after the edge with inputs idle and the model updated.
   task automatic drive(input logic v, input logic [7:0] d, input logic e,
                        input logic rd, input logic fl);
      bit pop_ok;
      i_rx_data_valid = v;
      i_rx_data       = d;
      i_rx_error      = e;
      i_rd_en         = rd;
      i_flush         = fl;
      @(posedge clk);
      #1;
      i_rx_data_valid = 1'b0;
      i_rx_data       = 8'h00;
      i_rx_error      = 1'b0;
      i_rd_en         = 1'b0;
      i_flush         = 1'b0;
      if (fl) begin
         exp_q.delete();
         m_ovr  = 1'b0;
         m_ferr = 1'b0;
      end else begin
         pop_ok = rd && (exp_q.size() > 0);
         if (v) begin
            if (exp_q.size() < DEPTH || pop_ok) begin
               exp_q.push_back({e, d});
               if (e) m_ferr = 1'b1;
            end else begin
               m_ovr = 1'b1;
            end
         end
         if (pop_ok) void'(exp_q.pop_front());
      end
   endtask

   task automatic push(input logic [7:0] d, input logic e);
      drive(1'b1, d, e, 1'b0, 1'b0);
   endtask

   task automatic pop();
      drive(1'b0, 8'h00, 1'b0, 1'b1, 1'b0);
   endtask

   task automatic do_flush();
      drive(1'b0, 8'h00, 1'b0, 1'b0, 1'b1);
   endtask

   task automatic test_reset();
      rst_n = 1'b0;
      repeat (3) @(posedge clk);
      #1;
      rst_n = 1'b1;
      exp_q.delete();
      m_ovr = 1'b0;
      m_ferr = 1'b0;
      checks++;
      if ({o_empty, o_full, o_level, o_overrun, o_frame_err, o_irq, o_rdata, o_rdata_err}
          !== {1'b1, 1'b0, 4'd0, 1'b0, 1'b0, 1'b0, 8'h00, 1'b0}) begin
         errors++;
         $display("FAIL reset_state: empty=%b full=%b level=%0d ovr=%b ferr=%b irq=%b rdata=%h err=%b, required empty=1 rest 0",
                  o_empty, o_full, o_level, o_overrun, o_frame_err, o_irq, o_rdata, o_rdata_err);
      end
      // Reset asserted mid-operation must clear state asynchronously.
      push(8'h12, 1'b1);
      push(8'h34, 1'b0);
      #2 rst_n = 1'b0;
      #1;
      checks++;
      if ({o_level, o_empty, o_frame_err, o_irq, o_rdata} !== {4'd0, 1'b1, 1'b0, 1'b0, 8'h00}) begin
         errors++;
         $display("FAIL async_reset: level=%0d empty=%b ferr=%b irq=%b rdata=%h, required 0 1 0 0 00",
                  o_level, o_empty, o_frame_err, o_irq, o_rdata);
      end
      @(posedge clk);
      #1;
      rst_n = 1'b1;
      exp_q.delete();
      m_ovr = 1'b0;
      m_ferr = 1'b0;
   endtask

   task automatic test_basic();
      push(8'h55, 1'b0);
      checks++;
      if ({o_level, o_rdata, o_irq} !== {4'd1, 8'h55, 1'b1}) begin
         errors++;
         $display("FAIL basic_latency: level=%0d rdata=%h irq=%b, required 1 55 1", o_level, o_rdata, o_irq);
      end
      push(8'hA3, 1'b0);
      checks++;
      if ({o_level, o_rdata} !== {4'd2, 8'h55}) begin
         errors++;
         $display("FAIL basic_two: level=%0d rdata=%h, required 2 55", o_level, o_rdata);
      end
      pop();
      checks++;
      if ({o_level, o_rdata} !== {4'd1, 8'hA3}) begin
         errors++;
         $display("FAIL basic_pop: level=%0d rdata=%h, required 1 a3", o_level, o_rdata);
      end
      pop();
      checks++;
      if ({o_empty, o_rdata, o_irq} !== {1'b1, 8'h00, 1'b0}) begin
         errors++;
         $display("FAIL basic_empty: empty=%b rdata=%h irq=%b, required 1 00 0", o_empty, o_rdata, o_irq);
      end
      // rd_en on empty together with a push: pop ignored, push kept.
      drive(1'b1, 8'h6B, 1'b0, 1'b1, 1'b0);
      checks++;
      if ({o_level, o_rdata} !== {4'd1, 8'h6B}) begin
         errors++;
         $display("FAIL empty_rd_push: level=%0d rdata=%h, required 1 6b", o_level, o_rdata);
      end
      pop();
      pop();
      checks++;
      if ({o_level, o_empty} !== {4'd0, 1'b1}) begin
         errors++;
         $display("FAIL underflow: level=%0d empty=%b, required 0 1", o_level, o_empty);
      end
   endtask

   task automatic test_overrun();
      for (int i = 0; i < DEPTH; i++) push(8'(i), 1'b0);
      checks++;
      if ({o_full, o_level, o_overrun} !== {1'b1, 4'd8, 1'b0}) begin
         errors++;
         $display("FAIL fill: full=%b level=%0d ovr=%b, required 1 8 0", o_full, o_level, o_overrun);
      end
      push(8'hFF, 1'b1);
      checks++;
      if ({o_overrun, o_level, o_frame_err} !== {1'b1, 4'd8, 1'b0}) begin
         errors++;
         $display("FAIL overrun: ovr=%b level=%0d ferr=%b, required 1 8 0", o_overrun, o_level, o_frame_err);
      end
      for (int i = 0; i < DEPTH; i++) begin
         checks++;
         if (o_rdata !== 8'(i)) begin
            errors++;
            $display("FAIL drain_order[%0d]: rdata=%h, required %h", i, o_rdata, 8'(i));
         end
         pop();
      end
      checks++;
      if ({o_empty, o_rdata, o_overrun, o_irq} !== {1'b1, 8'h00, 1'b1, 1'b1}) begin
         errors++;
         $display("FAIL drain_end: empty=%b rdata=%h ovr=%b irq=%b, required 1 00 1 1",
                  o_empty, o_rdata, o_overrun, o_irq);
      end
      do_flush();
   endtask

   task automatic test_full_pop();
      for (int i = 0; i < DEPTH; i++) push(8'(8'h10 + i), 1'b0);
      drive(1'b1, 8'h99, 1'b0, 1'b1, 1'b0);
      checks++;
      if ({o_level, o_overrun, o_full, o_rdata} !== {4'd8, 1'b0, 1'b1, 8'h11}) begin
         errors++;
         $display("FAIL full_pop_push: level=%0d ovr=%b full=%b rdata=%h, required 8 0 1 11",
                  o_level, o_overrun, o_full, o_rdata);
      end
      repeat (DEPTH - 1) pop();
      checks++;
      if ({o_level, o_rdata} !== {4'd1, 8'h99}) begin
         errors++;
         $display("FAIL full_pop_last: level=%0d rdata=%h, required 1 99", o_level, o_rdata);
      end
      pop();
   endtask

   task automatic test_frame_err();
      push(8'h3C, 1'b1);
      checks++;
      if ({o_rdata, o_rdata_err, o_frame_err, o_irq} !== {8'h3C, 1'b1, 1'b1, 1'b1}) begin
         errors++;
         $display("FAIL frame_push: rdata=%h err=%b ferr=%b irq=%b, required 3c 1 1 1",
                  o_rdata, o_rdata_err, o_frame_err, o_irq);
      end
      pop();
      checks++;
      if ({o_rdata_err, o_frame_err, o_irq, o_empty} !== {1'b0, 1'b1, 1'b1, 1'b1}) begin
         errors++;
         $display("FAIL frame_sticky: err=%b ferr=%b irq=%b empty=%b, required 0 1 1 1",
                  o_rdata_err, o_frame_err, o_irq, o_empty);
      end
      do_flush();
      checks++;
      if ({o_frame_err, o_irq} !== {1'b0, 1'b0}) begin
         errors++;
         $display("FAIL frame_flush: ferr=%b irq=%b, required 0 0", o_frame_err, o_irq);
      end
   endtask

   task automatic test_flush();
      for (int i = 0; i < DEPTH; i++) push(8'(8'h40 + i), 1'b1);
      push(8'hEE, 1'b0);
      repeat (3) pop();
      checks++;
      if ({o_level, o_overrun, o_frame_err} !== {4'd5, 1'b1, 1'b1}) begin
         errors++;
         $display("FAIL flush_setup: level=%0d ovr=%b ferr=%b, required 5 1 1", o_level, o_overrun, o_frame_err);
      end
      drive(1'b1, 8'h11, 1'b1, 1'b0, 1'b1);
      checks++;
      if ({o_level, o_empty, o_overrun, o_frame_err, o_irq, o_rdata}
          !== {4'd0, 1'b1, 1'b0, 1'b0, 1'b0, 8'h00}) begin
         errors++;
         $display("FAIL flush_priority: level=%0d empty=%b ovr=%b ferr=%b irq=%b rdata=%h, required 0 1 0 0 0 00",
                  o_level, o_empty, o_overrun, o_frame_err, o_irq, o_rdata);
      end
   endtask

   task automatic test_wrap();
      for (int r = 0; r < 3; r++) begin
         for (int i = 0; i < 4; i++) push(8'(r * 16 + i + 8'hA0), 1'b0);
         for (int i = 0; i < 4; i++) begin
            checks++;
            if (o_rdata !== 8'(r * 16 + i + 8'hA0)) begin
               errors++;
               $display("FAIL wrap_order r%0d i%0d: rdata=%h, required %h", r, i, o_rdata, 8'(r * 16 + i + 8'hA0));
            end
            pop();
         end
         checks++;
         if (o_level !== 4'd0) begin
            errors++;
            $display("FAIL wrap_level r%0d: level=%0d, required 0", r, o_level);
         end
      end
   endtask

   task automatic test_random();
      logic [7:0] exp_rdata;
      logic       exp_err;
      logic       exp_irq;
      for (int n = 0; n < 400; n++) begin
         drive(1'($urandom_range(0, 99) < 55), 8'($urandom), 1'($urandom_range(0, 9) == 0),
               1'($urandom_range(0, 99) < 45), 1'($urandom_range(0, 59) == 0));
         exp_rdata = (exp_q.size() > 0) ? exp_q[0][7:0] : 8'h00;
         exp_err   = (exp_q.size() > 0) ? exp_q[0][8] : 1'b0;
         exp_irq   = (exp_q.size() >= IRQ_LEVEL) || m_ovr || m_ferr;
         checks++;
         if ({o_rdata, o_rdata_err, o_level, o_empty, o_full, o_overrun, o_frame_err, o_irq}
             !== {exp_rdata, exp_err, 4'(exp_q.size()), exp_q.size() == 0, exp_q.size() == DEPTH,
                  m_ovr, m_ferr, exp_irq}) begin
            errors++;
            $display("FAIL random[%0d]: rdata=%h err=%b level=%0d empty=%b full=%b ovr=%b ferr=%b irq=%b, required %h %b %0d %b %b %b %b %b",
                     n, o_rdata, o_rdata_err, o_level, o_empty, o_full, o_overrun, o_frame_err, o_irq,
                     exp_rdata, exp_err, exp_q.size(), exp_q.size() == 0, exp_q.size() == DEPTH,
                     m_ovr, m_ferr, exp_irq);
         end
      end
   endtask

   initial begin
      rst_n           = 1'b0;
      i_rx_data_valid = 1'b0;
      i_rx_data       = 8'h00;
      i_rx_error      = 1'b0;
      i_rd_en         = 1'b0;
      i_flush         = 1'b0;
      m_ovr           = 1'b0;
      m_ferr          = 1'b0;
      @(negedge clk);
      test_reset();
      test_basic();
      test_overrun();
      test_full_pop();
      test_frame_err();
      test_flush();
      test_wrap();
      test_random();
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
